// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared sizes and loader FSM encoding for the instruction memory write path.
package inst_mem_pkg;
    localparam int MEM_BYTES      = 1024;
    localparam int ADDR_W         = $clog2(MEM_BYTES);
    localparam int BYTES_PER_WORD = 4;
    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} loader_state_t;
endpackage

// File: rtl/word_byte_serializer.sv
// word_byte_serializer: holds a 32-bit word and shifts it out MSB-first, one byte per shift.
module word_byte_serializer
    import inst_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        shift,
    input  logic [31:0] word,
    output logic [7:0]  byte_out,
    output logic        last
);
    logic [31:0] sh;
    logic [1:0]  idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh  <= '0;
            idx <= '0;
        end else if (load) begin
            sh  <= word;
            idx <= '0;
        end else if (shift) begin
            sh  <= {sh[23:0], 8'h00};
            idx <= idx + 2'd1;
        end
    end

    assign byte_out = sh[31:24];
    assign last     = idx == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: streams 32-bit words into the byte-wide instruction memory port, big-endian.
module inst_mem_loader #(
    parameter int ADDR_W = inst_mem_pkg::ADDR_W,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_word,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done
);
    import inst_mem_pkg::*;

    loader_state_t     state;
    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  words_left;
    logic [7:0]        byte_out;
    logic              last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_addr   <= '0;
            words_left <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cur_addr   <= base_addr & ~ADDR_W'(3);
                    words_left <= word_count;
                    state      <= (word_count == '0) ? DONE : ACCEPT;
                end
                ACCEPT: if (in_valid) state <= WRITE;
                WRITE: begin
                    cur_addr <= cur_addr + ADDR_W'(1);
                    if (last) begin
                        words_left <= words_left - CNT_W'(1);
                        state      <= (words_left == CNT_W'(1)) ? DONE : ACCEPT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    word_byte_serializer u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ACCEPT && in_valid),
        .shift    (state == WRITE),
        .word     (in_word),
        .byte_out (byte_out),
        .last     (last)
    );

    // All outputs decode from flops only, so they move on clock edges alone.
    assign in_ready  = state == ACCEPT;
    assign busy      = state == ACCEPT || state == WRITE;
    assign done      = state == DONE;
    assign mem_we    = state == WRITE;
    assign mem_addr  = mem_we ? cur_addr : '0;
    assign mem_wdata = mem_we ? byte_out : '0;
endmodule
